dx_issue_ctrl: RTL
==================

# dx_issue_ctrl

Execute-side issue controller for the 2-wide pipeline: consumes the decoded slot-0/slot-1 fields held in the DX latch and decides each cycle which slots enter execute. It serialises an intra-pair RAW dependency (slot 1 reads slot 0's destination) and blocks issue while a multi-cycle mult/div runs. It drives the DX latch's two write enables (lower slot-0 half, upper slot-1 half) and the stall to the FD stage.

## Interface
Parameters:
- MD_LATENCY, 16, cycles a mult/div occupies execute (≥2)

Ports:
- clock  in  1  pipeline clock, rising edge
- ctrl_reset  in  1  asynchronous, active-high reset
- dx_valid0 / dx_valid1  in  1  slot holds a real instruction
- dx_rd0  in  5  slot-0 destination register
- dx_wr0  in  1  slot 0 writes dx_rd0
- dx_rs1 / dx_rt1  in  5  slot-1 source registers
- dx_md0 / dx_md1  in  1  slot is mult/div
- issue0 / issue1  out  1  slot enters execute this cycle
- dx_we0  out  1  write enable, DX latch lower half (slot 0)
- dx_we1  out  1  write enable, DX latch upper half (slot 1)
- fd_stall  out  1  hold FD latch and PC
- md_busy  out  1  mult/div in flight

## Operation
- hazard = dx_valid0 & dx_valid1 & dx_wr0 & (dx_rd0 != 0) & (dx_rs1 == dx_rd0 | dx_rt1 == dx_rd0).
- States: NORMAL, SPLIT, MD_WAIT. Registers: state, 5+ bit down-counter cnt, pending (slot 1 still owed).
- NORMAL, no hazard, no md: issue0 = dx_valid0, issue1 = dx_valid1, dx_we0 = dx_we1 = 1, fd_stall = 0; stay.
- NORMAL, hazard, !(dx_valid0 & dx_md0): issue0 = 1, issue1 = 0, dx_we0 = dx_we1 = 0, fd_stall = 1; → SPLIT.
- NORMAL, dx_valid0 & dx_md0: issue0 = 1, issue1 = 0, hold both halves, fd_stall = 1, cnt ← MD_LATENCY−1, pending ← dx_valid1; → MD_WAIT. md0 takes priority over hazard.
- NORMAL, no hazard, dx_valid1 & dx_md1 (md0 clear): issue both, hold both halves, fd_stall = 1, cnt ← MD_LATENCY−1, pending ← 0; → MD_WAIT.
- SPLIT: issue0 = 0, issue1 = 1, dx_we0 = dx_we1 = 1, fd_stall = 0; → NORMAL. If dx_md1: hold both halves, fd_stall = 1, cnt ← MD_LATENCY−1; → MD_WAIT, pending 0.
- MD_WAIT: no issue, dx_we0 = dx_we1 = 0, fd_stall = 1, md_busy = 1, cnt decrements; when cnt == 0 → SPLIT if pending else NORMAL with dx_we0 = dx_we1 = 1, fd_stall = 0 that cycle, so a new pair loads on that edge. Hold asserts only while a transition occurs.
- Invalid slots never issue; dx_valid0 = 0 with dx_valid1 = 1 issues slot 1 alone (no hazard possible).

## Timing
- issue/we/stall outputs combinational from state and dx_* inputs; state, cnt and pending update on the rising clock edge.
- Hazard pair: slot 0 issues cycle N, slot 1 cycle N+1, new pair in DX from N+2.
- Mult/div issued cycle N: md_busy high N+1..N+MD_LATENCY−1; next issue (pending slot 1 or new pair) at N+MD_LATENCY.
- Reset (asynchronous, any state, including mid-MD_WAIT): state = NORMAL, cnt = 0, pending = 0, md_busy = 0; while ctrl_reset high, issue0 = issue1 = 0, fd_stall = 0, dx_we0 = dx_we1 = 1.

## Configuration
- DX_ISSUE_MD_EN defined: mult/div tracking, MD_WAIT and counter present as above.
- Undefined: dx_md0/dx_md1 ignored, MD_WAIT and cnt removed, md_busy tied 0; only NORMAL/SPLIT remain.

## Structure
- dx_issue_pkg: state enum (NORMAL, SPLIT, MD_WAIT), REG_W = 5, counter-width function of MD_LATENCY.
- One sub-module: dx_md_counter (load, decrement, zero flag), instantiated only under DX_ISSUE_MD_EN.

## Test plan
- Independent pair rd0 = 3, rs1 = 4, rt1 = 5, wr0 = 1 -> issue0 = issue1 = 1, we both 1, no stall, stays NORMAL.
- rd0 = 7, wr0 = 1, rs1 = 7 -> cycle N issue0 only, fd_stall = 1; N+1 issue1 only, we both 1; N+2 NORMAL.
- rd0 = 0, rt1 = 0, wr0 = 1 -> no hazard, both issue same cycle.
- MD_LATENCY = 4, dx_md0 = 1, dx_valid1 = 1 -> N issue0; md_busy N+1..N+3, no issue; N+4 issue1; N+5 NORMAL.
- Hazard pair plus dx_md1 = 1 -> N issue0, N+1 issue1 and MD_WAIT, next issue at N+1+MD_LATENCY.
- ctrl_reset asserted mid-MD_WAIT at cnt = 2 -> immediately md_busy = 0, issue0/1 = 0, we both 1; after release, NORMAL with pending cleared.

Source files
------------

// File: rtl/dx_issue_pkg.sv
// dx_issue_pkg: shared types for the DX issue controller.
// Mult/div tracking is built only when DX_ISSUE_MD_EN is defined.
package dx_issue_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SPLIT   = 2'd1,
    MD_WAIT = 2'd2
  } dx_state_e;

  // Counter width for a mult/div occupancy of lat cycles (never below 5).
  function automatic int cnt_w(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 5) ? 5 : w;
  endfunction

endpackage

// File: rtl/dx_md_counter.sv
// dx_md_counter: mult/div occupancy down-counter.
// zero_next flags the wait cycle whose decrement reaches zero.
module dx_md_counter #(
  parameter int W    = 5,
  parameter int LOAD = 15
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic load,
  input  logic dec,
  output logic zero_next
);

  logic [W-1:0] cnt_q;

  // Load on mult/div issue, count down while waiting, saturate at zero.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(LOAD);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Last wait cycle: the count leaves one (or is already spent).
  assign zero_next = (cnt_q <= W'(1));

endmodule

// File: rtl/dx_issue_ctrl.sv
// dx_issue_ctrl: 2-wide execute issue control (RAW split, mult/div hold).
// DX_ISSUE_MD_EN adds mult/div tracking (MD_WAIT state and counter).
module dx_issue_ctrl
  import dx_issue_pkg::*;
#(
  parameter int MD_LATENCY = 16
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             dx_valid0,
  input  logic             dx_valid1,
  input  logic [REG_W-1:0] dx_rd0,
  input  logic             dx_wr0,
  input  logic [REG_W-1:0] dx_rs1,
  input  logic [REG_W-1:0] dx_rt1,
  input  logic             dx_md0,
  input  logic             dx_md1,
  output logic             issue0,
  output logic             issue1,
  output logic             dx_we0,
  output logic             dx_we1,
  output logic             fd_stall,
  output logic             md_busy
);

  dx_state_e state_q;
  dx_state_e state_d;
  logic      pending_q;
  logic      pending_d;
  logic      hazard;
  logic      md0_go;
  logic      md1_go;
  logic      md_load;
  logic      md_dec;

`ifdef DX_ISSUE_MD_EN
  logic md_zero;

  dx_md_counter #(
    .W    (cnt_w(MD_LATENCY)),
    .LOAD (MD_LATENCY - 1)
  ) u_md_cnt (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .load       (md_load),
    .dec        (md_dec),
    .zero_next  (md_zero)
  );

  assign md0_go = dx_valid0 & dx_md0;
  assign md1_go = dx_valid1 & dx_md1;
`else
  logic unused_md;

  assign md0_go    = 1'b0;
  assign md1_go    = 1'b0;
  assign unused_md = ^{dx_md0, dx_md1, md_load,
                       md_dec, pending_q, MD_LATENCY[0]};
`endif

  // Slot 1 reads a register slot 0 is about to write.
  assign hazard = dx_valid0 & dx_valid1 & dx_wr0
                & (dx_rd0 != '0)
                & ((dx_rs1 == dx_rd0) | (dx_rt1 == dx_rd0));

  assign md_busy = (state_q == MD_WAIT);

  // Issue decision, latch enables and next state.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    issue0    = 1'b0;
    issue1    = 1'b0;
    dx_we0    = 1'b1;
    dx_we1    = 1'b1;
    fd_stall  = 1'b0;
    md_load   = 1'b0;
    md_dec    = 1'b0;
    unique case (state_q)
      NORMAL: begin
        if (md0_go) begin
          issue0    = 1'b1;
          dx_we0    = 1'b0;
          dx_we1    = 1'b0;
          fd_stall  = 1'b1;
          md_load   = 1'b1;
          pending_d = dx_valid1;
          state_d   = MD_WAIT;
        end else if (hazard) begin
          issue0   = 1'b1;
          dx_we0   = 1'b0;
          dx_we1   = 1'b0;
          fd_stall = 1'b1;
          state_d  = SPLIT;
        end else if (md1_go) begin
          issue0    = dx_valid0;
          issue1    = 1'b1;
          dx_we0    = 1'b0;
          dx_we1    = 1'b0;
          fd_stall  = 1'b1;
          md_load   = 1'b1;
          pending_d = 1'b0;
          state_d   = MD_WAIT;
        end else begin
          issue0 = dx_valid0;
          issue1 = dx_valid1;
        end
      end
      SPLIT: begin
        issue1  = dx_valid1;
        state_d = NORMAL;
        if (md1_go) begin
          dx_we0    = 1'b0;
          dx_we1    = 1'b0;
          fd_stall  = 1'b1;
          md_load   = 1'b1;
          pending_d = 1'b0;
          state_d   = MD_WAIT;
        end
      end
`ifdef DX_ISSUE_MD_EN
      MD_WAIT: begin
        dx_we0   = 1'b0;
        dx_we1   = 1'b0;
        fd_stall = 1'b1;
        md_dec   = 1'b1;
        if (md_zero) begin
          pending_d = 1'b0;
          if (pending_q) begin
            state_d = SPLIT;
          end else begin
            state_d  = NORMAL;
            dx_we0   = 1'b1;
            dx_we1   = 1'b1;
            fd_stall = 1'b0;
          end
        end
      end
`endif
      default: begin
        state_d   = NORMAL;
        pending_d = 1'b0;
      end
    endcase
    if (ctrl_reset) begin
      issue0   = 1'b0;
      issue1   = 1'b0;
      dx_we0   = 1'b1;
      dx_we1   = 1'b1;
      fd_stall = 1'b0;
    end
  end

  // State and owed-slot-1 flag.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q   <= NORMAL;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
